// File: rtl/quad_paddle.sv
// Multi-channel quadrature paddle: synchronizer, per-bit debouncer, quadrature decoder and
// saturating position counter. Define QUAD_PADDLE_WRAP_EN to wrap positions modulo MAX_POS+1.
module quad_paddle #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned MAX_POS   = 200,
    parameter int unsigned RESET_POS = 100,
    parameter int unsigned STEP      = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       a,
    input  logic [CHANNELS-1:0]       b,
    input  logic                      center,
    input  logic                      err_clr,
    output logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS-1:0]       moved,
    output logic [CHANNELS-1:0]       err
);
    localparam int unsigned AW = WIDTH + 1;
    localparam logic [AW-1:0]    MaxPos   = AW'(MAX_POS);
    localparam logic [AW-1:0]    StepW    = AW'(STEP);
    localparam logic [WIDTH-1:0] ResetPos = WIDTH'(RESET_POS);
    localparam logic [7:0]       DbLast   = 8'(DB_CYCLES - 1);
`ifdef QUAD_PADDLE_WRAP_EN
    localparam logic [AW-1:0]    Modulus  = AW'(MAX_POS + 1);
`endif

    // Index of an {A,B} pair along the forward cycle 00 -> 01 -> 11 -> 10.
    function automatic logic [1:0] phase(input logic [1:0] ab);
        case (ab)
            2'b00:   phase = 2'd0;
            2'b01:   phase = 2'd1;
            2'b11:   phase = 2'd2;
            default: phase = 2'd3;
        endcase
    endfunction

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [1:0]       sync1_q, sync2_q, deb_q, prev_q;
        logic [1:0][7:0]  cnt_q;
        logic [WIDTH-1:0] pos_q;
        logic             moved_q, err_q;
        logic [1:0]       delta;
        logic             fwd, rev, illegal, moved_d;
        logic [AW-1:0]    ext, sum;
        logic [WIDTH-1:0] nxt;

        always_comb begin
            delta   = phase(deb_q) - phase(prev_q);
            fwd     = (delta == 2'd1);
            rev     = (delta == 2'd3);
            illegal = (delta == 2'd2);
            ext     = {1'b0, pos_q};
            sum     = ext + StepW;
            nxt     = pos_q;
`ifdef QUAD_PADDLE_WRAP_EN
            if (fwd) begin
                nxt = WIDTH'((sum > MaxPos) ? sum - Modulus : sum);
            end else if (rev) begin
                nxt = WIDTH'((ext < StepW) ? ext + Modulus - StepW : ext - StepW);
            end
            moved_d = fwd | rev;
`else
            if (fwd) begin
                nxt = WIDTH'((sum > MaxPos) ? MaxPos : sum);
            end else if (rev) begin
                nxt = WIDTH'((ext < StepW) ? '0 : ext - StepW);
            end
            moved_d = (nxt != pos_q);
`endif
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1_q <= '0;
                sync2_q <= '0;
                deb_q   <= '0;
                prev_q  <= '0;
                cnt_q   <= '0;
                pos_q   <= ResetPos;
                moved_q <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                sync1_q <= {a[ch], b[ch]};
                sync2_q <= sync1_q;
                prev_q  <= deb_q;
                // Accept a new level only after DB_CYCLES consecutive disagreeing samples.
                for (int i = 0; i < 2; i++) begin
                    if (sync2_q[i] == deb_q[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] == DbLast) begin
                        deb_q[i] <= sync2_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 8'd1;
                    end
                end
                if (center) begin
                    pos_q   <= ResetPos;
                    moved_q <= 1'b0;
                end else begin
                    pos_q   <= nxt;
                    moved_q <= moved_d;
                end
                err_q <= (err_q & ~err_clr) | illegal;
            end
        end

        assign value[ch*WIDTH +: WIDTH] = pos_q;
        assign moved[ch]                = moved_q;
        assign err[ch]                  = err_q;
    end

endmodule

// File: tb/tb_quad_paddle.sv
// Bench for quad_paddle: vector table, hand-written corner sequences and random stimulus
// checked every cycle against a behavioural model. Honours QUAD_PADDLE_WRAP_EN.
module tb_quad_paddle;
    localparam int W    = 8;
    localparam int CH   = 2;
    localparam int DB   = 4;
    localparam int MAXP = 200;
    localparam int RP   = 100;
    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  a = '0, b = '0;
    logic        center = 1'b0, err_clr = 1'b0;
    logic [15:0] value;
    logic [1:0]  moved, err;

    int vectors = 0;
    int miscompares = 0;

    quad_paddle #(
        .WIDTH(W), .CHANNELS(CH), .DB_CYCLES(DB), .MAX_POS(MAXP), .RESET_POS(RP), .STEP(STEP)
    ) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .center(center), .err_clr(err_clr),
        .value(value), .moved(moved), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: a 2-sample delay line, a window of recent samples for debounce,
    // and plain integer position arithmetic.
    int m_s1[CH][2], m_s2[CH][2], m_deb[CH][2], m_hist[CH][2][DB];
    int m_prev[CH], m_pos[CH], m_mov[CH], m_err[CH];
    int ph[4] = '{0, 1, 3, 2};

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            for (int j = 0; j < 2; j++) begin
                m_s1[c][j] = 0; m_s2[c][j] = 0; m_deb[c][j] = 0;
                for (int k = 0; k < DB; k++) m_hist[c][j][k] = 0;
            end
            m_prev[c] = 0; m_pos[c] = RP; m_mov[c] = 0; m_err[c] = 0;
        end
    endtask

    task automatic model_step(input logic [1:0] ia, input logic [1:0] ib, input logic ic,
                              input logic iclr);
        for (int c = 0; c < CH; c++) begin
            int cur, d, np, mv, all_diff;
            cur = m_deb[c][1] * 2 + m_deb[c][0];
            d   = (ph[cur] - ph[m_prev[c]] + 4) % 4;
            np  = m_pos[c];
            if (d == 1) np = m_pos[c] + STEP;
            else if (d == 3) np = m_pos[c] - STEP;
`ifdef QUAD_PADDLE_WRAP_EN
            np = (np + MAXP + 1) % (MAXP + 1);
            mv = (d == 1 || d == 3) ? 1 : 0;
`else
            if (np > MAXP) np = MAXP;
            if (np < 0) np = 0;
            mv = (np != m_pos[c]) ? 1 : 0;
`endif
            if (ic) begin
                np = RP;
                mv = 0;
            end
            m_pos[c]  = np;
            m_mov[c]  = mv;
            m_err[c]  = (iclr ? 0 : m_err[c]) | ((d == 2) ? 1 : 0);
            m_prev[c] = cur;
            for (int j = 0; j < 2; j++) begin
                for (int k = DB - 1; k > 0; k--) m_hist[c][j][k] = m_hist[c][j][k-1];
                m_hist[c][j][0] = m_s2[c][j];
                all_diff = 1;
                for (int k = 0; k < DB; k++) if (m_hist[c][j][k] == m_deb[c][j]) all_diff = 0;
                if (all_diff != 0) m_deb[c][j] = m_s2[c][j];
                m_s2[c][j] = m_s1[c][j];
                m_s1[c][j] = (j == 1) ? int'(ia[c]) : int'(ib[c]);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [7:0] p0, p1;
        p0 = 8'(m_pos[0]);
        p1 = 8'(m_pos[1]);
        check("model value", 32'(value), 32'({p1, p0}));
        check("model moved", 32'(moved), 32'({m_mov[1] != 0, m_mov[0] != 0}));
        check("model err", 32'(err), 32'({m_err[1] != 0, m_err[0] != 0}));
    endtask

    task automatic tick(input logic [1:0] ia, input logic [1:0] ib, input logic ic,
                        input logic iclr);
        @(negedge clk);
        reset = 1'b0; a = ia; b = ib; center = ic; err_clr = iclr;
        @(posedge clk);
        model_step(ia, ib, ic, iclr);
        #1;
        check_model();
    endtask

    // Reset with center/err_clr asserted too, so reset priority is exercised every time.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; a = '0; b = '0; center = 1'b1; err_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset value", 32'(value), 32'(16'h6464));
        check("reset moved", 32'(moved), 32'(0));
        check("reset err", 32'(err), 32'(0));
        model_reset();
    endtask

    typedef struct {
        logic [1:0] a, b;
        logic       center, err_clr;
        int         hold;
        int         exp0, exp1;
        logic [1:0] exp_err;
    } vec_t;

    vec_t tbl[13];
    logic [1:0] seq[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    initial begin
        int sat_seen, late_moves;
        tbl[0]  = '{2'b00, 2'b01, 1'b0, 1'b0, 8, 101, 100, 2'b00};
        tbl[1]  = '{2'b01, 2'b01, 1'b0, 1'b0, 8, 102, 100, 2'b00};
        tbl[2]  = '{2'b01, 2'b00, 1'b0, 1'b0, 8, 103, 100, 2'b00};
        tbl[3]  = '{2'b00, 2'b00, 1'b0, 1'b0, 8, 104, 100, 2'b00};
        tbl[4]  = '{2'b01, 2'b00, 1'b0, 1'b0, 8, 103, 100, 2'b00};
        tbl[5]  = '{2'b10, 2'b10, 1'b0, 1'b0, 8, 104, 100, 2'b10};
        tbl[6]  = '{2'b10, 2'b10, 1'b0, 1'b1, 8, 104, 100, 2'b00};
        tbl[7]  = '{2'b10, 2'b00, 1'b0, 1'b0, 8, 104, 101, 2'b00};
        tbl[8]  = '{2'b00, 2'b00, 1'b0, 1'b0, 8, 104, 102, 2'b00};
        tbl[9]  = '{2'b00, 2'b10, 1'b0, 1'b0, 8, 104, 103, 2'b00};
        tbl[10] = '{2'b00, 2'b00, 1'b0, 1'b0, 8, 104, 102, 2'b00};
        tbl[11] = '{2'b00, 2'b00, 1'b1, 1'b0, 1, 100, 100, 2'b00};
        tbl[12] = '{2'b01, 2'b01, 1'b0, 1'b0, 8, 100, 100, 2'b01};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            for (int h = 0; h < tbl[i].hold; h++)
                tick(tbl[i].a, tbl[i].b, tbl[i].center, tbl[i].err_clr);
            check($sformatf("vec%0d value0", i), 32'(value[7:0]), 32'(tbl[i].exp0));
            check($sformatf("vec%0d value1", i), 32'(value[15:8]), 32'(tbl[i].exp1));
            check($sformatf("vec%0d err", i), 32'(err), 32'(tbl[i].exp_err));
        end

        // Single forward step: value and moved land on the 7th edge.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            tick(2'b00, 2'b01, 1'b0, 1'b0);
            check("latency value0", 32'(value[7:0]), (k >= 7) ? 32'd101 : 32'd100);
            check("latency moved", 32'(moved), (k == 7) ? 32'd1 : 32'd0);
            check("latency value1", 32'(value[15:8]), 32'd100);
        end

        // Three-cycle glitch on a[0] is rejected.
        do_reset();
        for (int k = 0; k < 11; k++) begin
            tick((k < 3) ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b0);
            check("glitch value", 32'(value), 32'(16'h6464));
            check("glitch moved", 32'(moved), 32'd0);
        end

        // Saturation (or wrap) on channel 1.
        do_reset();
        sat_seen = 0;
        late_moves = 0;
        for (int k = 1; k <= 110; k++) begin
            for (int h = 0; h < 6; h++) begin
                tick({seq[k%4][1], 1'b0}, {seq[k%4][0], 1'b0}, 1'b0, 1'b0);
                if (sat_seen != 0 && moved[1]) late_moves++;
                if (value[15:8] == 8'd200) sat_seen = 1;
            end
            if (k == 101 || k == 110) begin
                repeat (8) tick({seq[k%4][1], 1'b0}, {seq[k%4][0], 1'b0}, 1'b0, 1'b0);
`ifdef QUAD_PADDLE_WRAP_EN
                check("wrap value1", 32'(value[15:8]), (k == 101) ? 32'd0 : 32'd9);
`else
                check("saturate value1", 32'(value[15:8]), 32'd200);
`endif
                check("saturate value0", 32'(value[7:0]), 32'd100);
            end
        end
`ifndef QUAD_PADDLE_WRAP_EN
        check("moved after saturation", 32'(late_moves), 32'd0);
`endif

        // Illegal transition, clear, and clear coinciding with a new illegal transition.
        do_reset();
        repeat (8) tick(2'b01, 2'b01, 1'b0, 1'b0);
        check("illegal err", 32'(err), 32'd1);
        check("illegal value", 32'(value), 32'(16'h6464));
        tick(2'b01, 2'b01, 1'b0, 1'b1);
        check("err_clr err", 32'(err), 32'd0);
        repeat (7) tick(2'b00, 2'b00, 1'b0, 1'b1);
        check("err_clr vs new illegal", 32'(err), 32'd1);
        tick(2'b00, 2'b00, 1'b0, 1'b1);
        check("err_clr after", 32'(err), 32'd0);

        // center coincident with a channel 0 decode.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            tick(2'b00, 2'b01, (k == 7), 1'b0);
            if (k >= 7) begin
                check("center value", 32'(value), 32'(16'h6464));
                check("center moved", 32'(moved), 32'd0);
            end
        end

        // Random stimulus with random hold lengths (includes glitches and illegal pairs).
        do_reset();
        for (int s = 0; s < 250; s++) begin
            logic [1:0] ra, rb;
            int hold;
            ra = 2'($urandom);
            rb = 2'($urandom);
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++)
                tick(ra, rb, ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0));
        end
        // Reset while debounce/decode may be in flight, then keep going.
        do_reset();
        for (int s = 0; s < 20; s++) tick(2'($urandom), 2'($urandom), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
